// File: rtl/craft_tks_stream.sv
// craft_tks_stream: sequential CRAFT round-tweakey generator.
// Loads one 128-bit key and one 64-bit tweak, then streams TK[r] for
// r = 0..NUM_ROUNDS-1 (LANES tweakeys per beat) over a valid/ready port.
// Optional feature macro: CRAFT_TKS_DECRYPT_EN (descending round order on dec_i).
module craft_tks_stream #(
    parameter int NUM_ROUNDS = 32,
    parameter int LANES      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [127:0]          key_i,
    input  logic [63:0]           tweak_i,
    input  logic                  dec_i,
    output logic                  tk_valid_o,
    input  logic                  tk_ready_i,
    output logic [64*LANES-1:0]   tk_o,
    output logic [7:0]            round_o,
    output logic                  last_o
);

    typedef enum logic {IDLE, RUN} state_t;

    // Nibble i of this constant is the source nibble index Q[i].
    localparam logic [63:0] QTAB      = 64'hCAF5E892B374601D;
    localparam logic [7:0]  STEP      = 8'(LANES);
    localparam logic [7:0]  LAST_ENC  = 8'(NUM_ROUNDS - LANES);
`ifdef CRAFT_TKS_DECRYPT_EN
    localparam logic [7:0]  FIRST_DEC = 8'(NUM_ROUNDS - 1);
    localparam logic [7:0]  LAST_DEC  = 8'(LANES - 1);
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] k0_q, k0_d;
    logic [63:0] k1_q, k1_d;
    logic [63:0] t_q, t_d;
    logic [63:0] qt_q, qt_d;
    logic        last_beat;
`ifdef CRAFT_TKS_DECRYPT_EN
    logic        dec_q, dec_d;
`else
    logic        unused_dec;
    assign unused_dec = dec_i;
`endif

    // Tweak nibble permutation Q; nibble 0 is the most significant nibble.
    function automatic logic [63:0] q_perm(input logic [63:0] v);
        logic [63:0] res;
        logic [3:0]  src;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            src = QTAB[63-4*i -: 4];
            res[63-4*i -: 4] = v[63-4*int'(src) -: 4];
        end
        return res;
    endfunction

    // Tweakey for one round index from the registered key/tweak material.
    function automatic logic [63:0] tk_of(input logic [7:0] r,
                                          input logic [63:0] k0, input logic [63:0] k1,
                                          input logic [63:0] t,  input logic [63:0] qt);
        return (r[0] ? k1 : k0) ^ (r[1] ? qt : t);
    endfunction

    // Final-beat detection from the counter and direction.
    always_comb begin
`ifdef CRAFT_TKS_DECRYPT_EN
        last_beat = dec_q ? (cnt_q == LAST_DEC) : (cnt_q == LAST_ENC);
`else
        last_beat = (cnt_q == LAST_ENC);
`endif
    end

    // State and datapath register updates with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            t_q     <= '0;
            qt_q    <= '0;
`ifdef CRAFT_TKS_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            t_q     <= t_d;
            qt_q    <= qt_d;
`ifdef CRAFT_TKS_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    // Next-state: load in IDLE, advance the counter on each accepted beat in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        t_d     = t_q;
        qt_d    = qt_q;
`ifdef CRAFT_TKS_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid_i) begin
                    k0_d    = key_i[127:64];
                    k1_d    = key_i[63:0];
                    t_d     = tweak_i;
                    qt_d    = q_perm(tweak_i);
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef CRAFT_TKS_DECRYPT_EN
                    dec_d   = dec_i;
                    if (dec_i) cnt_d = FIRST_DEC;
`endif
                end
            end
            RUN: begin
                if (tk_ready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
`ifdef CRAFT_TKS_DECRYPT_EN
                        cnt_d = dec_q ? (cnt_q - STEP) : (cnt_q + STEP);
`else
                        cnt_d = cnt_q + STEP;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: zero in IDLE; in RUN one tweakey per lane from registered state.
    always_comb begin
        logic [7:0] r;
        r            = '0;
        load_ready_o = (state_q == IDLE);
        tk_valid_o   = (state_q == RUN);
        tk_o         = '0;
        round_o      = '0;
        last_o       = 1'b0;
        if (state_q == RUN) begin
            round_o = cnt_q;
            last_o  = last_beat;
            for (int j = 0; j < LANES; j++) begin
`ifdef CRAFT_TKS_DECRYPT_EN
                r = dec_q ? (cnt_q - 8'(j)) : (cnt_q + 8'(j));
`else
                r = cnt_q + 8'(j);
`endif
                tk_o[64*j +: 64] = tk_of(r, k0_q, k1_q, t_q, qt_q);
            end
        end
    end

endmodule

// File: tb/tb_craft_tks_stream.sv
// Directed bench for craft_tks_stream: one LANES=1 and one LANES=4 instance.
module tb_craft_tks_stream;

    localparam logic [63:0] TA  = 64'h0123456789ABCDEF;
    localparam logic [63:0] QA  = 64'hCAF5E892B374601D;
    localparam logic [63:0] KHI = 64'h0123456789ABCDEF;
    localparam logic [63:0] KLO = 64'hFEDCBA9876543210;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  key = '0;
    logic [63:0]   tweak = '0;
    logic          dec = 1'b0;

    logic          lv1 = 1'b0, rdy1 = 1'b0;
    logic          lr1, tv1, last1;
    logic [63:0]   tk1;
    logic [7:0]    rnd1;

    logic          lv4 = 1'b0, rdy4 = 1'b0;
    logic          lr4, tv4, last4;
    logic [255:0]  tk4;
    logic [7:0]    rnd4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    craft_tks_stream #(.NUM_ROUNDS(32), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .load_valid_i(lv1), .load_ready_o(lr1),
        .key_i(key), .tweak_i(tweak), .dec_i(dec), .tk_valid_o(tv1),
        .tk_ready_i(rdy1), .tk_o(tk1), .round_o(rnd1), .last_o(last1));

    craft_tks_stream #(.NUM_ROUNDS(32), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .load_valid_i(lv4), .load_ready_o(lr4),
        .key_i(key), .tweak_i(tweak), .dec_i(dec), .tk_valid_o(tv4),
        .tk_ready_i(rdy4), .tk_o(tk4), .round_o(rnd4), .last_o(last4));

    // Reference tweakey: K0/K1 by round parity, T or Q(T) by (r mod 4) < 2.
    function automatic logic [63:0] exp_tk(input logic [63:0] k0, input logic [63:0] k1,
                                           input logic [63:0] t, input logic [63:0] qt,
                                           input int r);
        return ((r % 2) != 0 ? k1 : k0) ^ ((r % 4) < 2 ? t : qt);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (lr1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b want=1", lr1); end
        total++; if (tv1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", tv1); end
        total++; if (tk1 !== 64'h0) begin bad++; $display("FAIL reset_tk1 got=%h want=0", tk1); end
        total++; if (rnd1 !== 8'd0 || last1 !== 1'b0) begin bad++; $display("FAIL reset_round_last1 got=%0d/%b want=0/0", rnd1, last1); end
        total++; if (lr4 !== 1'b1 || tv4 !== 1'b0 || tk4 !== 256'h0) begin bad++; $display("FAIL reset_dut4 got=%b/%b/%h want=1/0/0", lr4, tv4, tk4); end
    endtask

    task automatic test_enc_tweak;
        key = '0; tweak = TA; dec = 1'b0;
        lv1 = 1'b1; rdy1 = 1'b1;
        @(negedge clk);
        lv1 = 1'b0;
        for (int r = 0; r < 32; r++) begin
            logic [63:0] want;
            want = ((r % 4) < 2) ? TA : QA;
            total++; if (tv1 !== 1'b1 || rnd1 !== 8'(r)) begin bad++; $display("FAIL enc_round got=%b/%0d want=1/%0d", tv1, rnd1, r); end
            total++; if (tk1 !== want) begin bad++; $display("FAIL enc_tk r=%0d got=%h want=%h", r, tk1, want); end
            total++; if (last1 !== (r == 31)) begin bad++; $display("FAIL enc_last r=%0d got=%b", r, last1); end
            @(negedge clk);
        end
        total++; if (lr1 !== 1'b1 || tv1 !== 1'b0) begin bad++; $display("FAIL enc_back_idle got=%b/%b want=1/0", lr1, tv1); end
    endtask

    task automatic test_key;
        key = {KHI, KLO}; tweak = '0; dec = 1'b0;
        rdy1 = 1'b1;
        total++; if (tv1 !== 1'b0) begin bad++; $display("FAIL key_pre_valid got=%b want=0", tv1); end
        lv1 = 1'b1;
        @(negedge clk);
        lv1 = 1'b0;
        for (int r = 0; r < 32; r++) begin
            logic [63:0] want;
            want = (r % 2 == 0) ? KHI : KLO;
            total++; if (tv1 !== 1'b1 || rnd1 !== 8'(r)) begin bad++; $display("FAIL key_round got=%b/%0d want=1/%0d", tv1, rnd1, r); end
            total++; if (tk1 !== want) begin bad++; $display("FAIL key_tk r=%0d got=%h want=%h", r, tk1, want); end
            @(negedge clk);
        end
        total++; if (lr1 !== 1'b1) begin bad++; $display("FAIL key_back_idle got=%b want=1", lr1); end
    endtask

    task automatic test_lanes4;
        key = '0; tweak = TA; dec = 1'b0;
        lv4 = 1'b1; rdy4 = 1'b1;
        @(negedge clk);
        lv4 = 1'b0;
        total++; if (tk4 !== {QA, QA, TA, TA}) begin bad++; $display("FAIL l4_beat0 got=%h want=%h", tk4, {QA, QA, TA, TA}); end
        for (int b = 0; b < 8; b++) begin
            total++; if (tv4 !== 1'b1 || rnd4 !== 8'(4*b)) begin bad++; $display("FAIL l4_round got=%b/%0d want=1/%0d", tv4, rnd4, 4*b); end
            for (int j = 0; j < 4; j++) begin
                logic [63:0] want;
                want = exp_tk(64'h0, 64'h0, TA, QA, 4*b + j);
                total++; if (tk4[64*j +: 64] !== want) begin bad++; $display("FAIL l4_lane b=%0d j=%0d got=%h want=%h", b, j, tk4[64*j +: 64], want); end
            end
            total++; if (last4 !== (b == 7)) begin bad++; $display("FAIL l4_last b=%0d got=%b", b, last4); end
            @(negedge clk);
        end
        total++; if (lr4 !== 1'b1 || tv4 !== 1'b0) begin bad++; $display("FAIL l4_back_idle got=%b/%b want=1/0", lr4, tv4); end
        rdy4 = 1'b0;
    endtask

    task automatic test_backpressure;
        int          exp_r;
        int          cyc;
        logic        prev_rdy;
        logic [63:0] prev_tk;
        logic [7:0]  prev_rnd;
        logic        prev_last;
        key = {KHI, KLO}; tweak = TA; dec = 1'b0;
        rdy1 = 1'b0; lv1 = 1'b1;
        @(negedge clk);
        exp_r = 0; cyc = 0; prev_rdy = 1'b1;
        prev_tk = '0; prev_rnd = '0; prev_last = 1'b0;
        // Ignored loads in RUN carry a different key and tweak.
        key = 128'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A; tweak = 64'hFFFF0000FFFF0000;
        while (exp_r < 32 && cyc < 2000) begin
            total++; if (tv1 !== 1'b1 || rnd1 !== 8'(exp_r)) begin bad++; $display("FAIL bp_round got=%b/%0d want=1/%0d", tv1, rnd1, exp_r); end
            total++; if (tk1 !== exp_tk(KHI, KLO, TA, QA, exp_r)) begin bad++; $display("FAIL bp_tk r=%0d got=%h want=%h", exp_r, tk1, exp_tk(KHI, KLO, TA, QA, exp_r)); end
            total++; if (last1 !== (exp_r == 31)) begin bad++; $display("FAIL bp_last r=%0d got=%b", exp_r, last1); end
            if (!prev_rdy) begin
                total++; if (tk1 !== prev_tk || rnd1 !== prev_rnd || last1 !== prev_last) begin bad++; $display("FAIL bp_hold got=%h/%0d/%b want=%h/%0d/%b", tk1, rnd1, last1, prev_tk, prev_rnd, prev_last); end
            end
            prev_tk = tk1; prev_rnd = rnd1; prev_last = last1;
            rdy1 = 1'($urandom_range(0, 1));
            lv1  = 1'($urandom_range(0, 1));
            prev_rdy = rdy1;
            if (rdy1) exp_r++;
            cyc++;
            @(negedge clk);
        end
        lv1 = 1'b0; rdy1 = 1'b0;
        total++; if (exp_r != 32) begin bad++; $display("FAIL bp_timeout rounds=%0d want=32", exp_r); end
        total++; if (lr1 !== 1'b1 || tv1 !== 1'b0) begin bad++; $display("FAIL bp_back_idle got=%b/%b want=1/0", lr1, tv1); end
    endtask

    task automatic test_decrypt;
        key = {KHI, KLO}; tweak = TA; dec = 1'b1;
        rdy1 = 1'b1; lv1 = 1'b1;
        @(negedge clk);
        lv1 = 1'b0; dec = 1'b0;
`ifdef CRAFT_TKS_DECRYPT_EN
        total++; if (tk1 !== 64'h3429520AC520520D) begin bad++; $display("FAIL dec_tk31 got=%h want=3429520ac520520d", tk1); end
        for (int i = 0; i < 32; i++) begin
            int r;
            r = 31 - i;
            total++; if (rnd1 !== 8'(r) || tk1 !== exp_tk(KHI, KLO, TA, QA, r)) begin bad++; $display("FAIL dec_beat got=%0d/%h want=%0d/%h", rnd1, tk1, r, exp_tk(KHI, KLO, TA, QA, r)); end
            total++; if (last1 !== (r == 0)) begin bad++; $display("FAIL dec_last r=%0d got=%b", r, last1); end
            @(negedge clk);
        end
`else
        for (int r = 0; r < 32; r++) begin
            total++; if (rnd1 !== 8'(r) || tk1 !== exp_tk(KHI, KLO, TA, QA, r)) begin bad++; $display("FAIL dec_off_beat got=%0d/%h want=%0d/%h", rnd1, tk1, r, exp_tk(KHI, KLO, TA, QA, r)); end
            total++; if (last1 !== (r == 31)) begin bad++; $display("FAIL dec_off_last r=%0d got=%b", r, last1); end
            @(negedge clk);
        end
`endif
        total++; if (lr1 !== 1'b1 || tv1 !== 1'b0) begin bad++; $display("FAIL dec_back_idle got=%b/%b want=1/0", lr1, tv1); end
    endtask

    task automatic test_reset_mid;
        key = '0; tweak = TA; dec = 1'b0;
        rdy1 = 1'b1; lv1 = 1'b1;
        @(negedge clk);
        lv1 = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (rnd1 !== 8'd10) begin bad++; $display("FAIL mid_round got=%0d want=10", rnd1); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (lr1 !== 1'b1 || tv1 !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl got=%b/%b want=1/0", lr1, tv1); end
        total++; if (tk1 !== 64'h0 || rnd1 !== 8'd0 || last1 !== 1'b0) begin bad++; $display("FAIL mid_rst_data got=%h/%0d/%b want=0/0/0", tk1, rnd1, last1); end
        lv1 = 1'b1;
        @(negedge clk);
        lv1 = 1'b0;
        total++; if (tv1 !== 1'b1 || rnd1 !== 8'd0 || tk1 !== TA) begin bad++; $display("FAIL mid_restart got=%b/%0d/%h want=1/0/%h", tv1, rnd1, tk1, TA); end
        @(negedge clk);
        total++; if (rnd1 !== 8'd1 || tk1 !== TA) begin bad++; $display("FAIL mid_restart_r1 got=%0d/%h want=1/%h", rnd1, tk1, TA); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_enc_tweak;
        test_key;
        test_lanes4;
        test_backpressure;
        test_decrypt;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/craft_tks_stream.md
# craft_tks_stream

Sequential, parametrised CRAFT round-tweakey generator. It accepts one 128-bit key and one 64-bit tweak through a load handshake, then streams the round tweakeys TK[r] for r = 0..NUM_ROUNDS-1 over a valid/ready output port, LANES tweakeys per beat. It sits between the key/tweak input interface and the CRAFT round datapath and serves both iterative (LANES=1) and partially unrolled (LANES=2/4) cores.

## Interface
- NUM_ROUNDS, 32: rounds per schedule; must be a multiple of LANES, 1..255.
- LANES, 1: tweakeys per output beat; legal values 1, 2, 4.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- load_valid_i  in  1  key/tweak/dec offered.
- load_ready_o  out  1  block is idle and can accept a load.
- key_i  in  128  key; K0 = key_i[127:64], K1 = key_i[63:0].
- tweak_i  in  64  tweak T.
- dec_i  in  1  1 = emit rounds in descending order (see Configuration).
- tk_valid_o  out  1  tk_o/round_o valid.
- tk_ready_i  in  1  consumer accepts the current beat.
- tk_o  out  64*LANES  lane j at bits [64*j +: 64].
- round_o  out  8  round index of lane 0.
- last_o  out  1  current beat is the final one of the schedule.

## Operation
- Tweakey: TK[r] = Kr ^ Tr, where Kr = K0 for even r and K1 for odd r; Tr = T if (r mod 4) < 2, else Q(T).
- Q: nibble 0 is bits [63:60]. Output nibble i = input nibble Q[i], with Q = 12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13.
- States:
  - IDLE: load_ready_o=1, tk_valid_o=0.
  - RUN: load_ready_o=0, tk_valid_o=1.
- Load: load_valid_i & load_ready_o in IDLE does the following:
  - registers K0, K1, T and Q(T); Q(T) is computed once at load, not per round.
  - registers dec (dec is forced to 0 when the feature is compiled out).
  - sets the counter to 0 (encrypt) or NUM_ROUNDS-1 (decrypt).
  - moves to RUN.
- Lane mapping:
  - encrypt: lane j carries round round_o+j.
  - decrypt: lane j carries round round_o-j.
- Advance: on tk_valid_o & tk_ready_i, the counter moves by +LANES (encrypt) or -LANES (decrypt).
- last_o = 1 when:
  - encrypt: round_o = NUM_ROUNDS-LANES.
  - decrypt: round_o = LANES-1.
- Accepting the last_o beat returns the block to IDLE.
- Stall: while tk_ready_i=0, tk_o, round_o and last_o hold stable.
- In IDLE, tk_o, round_o and last_o are driven to 0.
- load_valid_i in RUN is ignored; no load is accepted.
- Counter arithmetic is 8-bit. It never wraps, because of the NUM_ROUNDS/LANES constraint.

## Timing
- Reset values: state IDLE, load_ready_o=1, tk_valid_o=0, tk_o=0, round_o=0, last_o=0. All key/tweak registers are cleared.
- Reset mid-schedule aborts immediately. The next cycle is IDLE with the reset values above.
- Load accepted at edge N → tk_valid_o=1 with the first beat from cycle N+1. Latency is 1 cycle.
- With tk_ready_i held at 1, beats are back-to-back, NUM_ROUNDS/LANES cycles in total.
- After the last beat is accepted at edge M:
  - load_ready_o=1 in cycle M+1.
  - a new load can be accepted at edge M+1; its first beat appears at M+2.
  - there is no combinational path load_valid_i → tk_valid_o.
- tk_o is a combinational function of registered state only (counter, K0/K1, T, Q(T)). There is no path from tk_ready_i to any output.
- load_ready_o depends on state only.

## Configuration
- CRAFT_TKS_DECRYPT_EN defined:
  - dec_i is honoured, and descending order is available for decryption cores.
- Not defined:
  - dec_i is ignored and the order is always ascending.
  - the decrement path and the decrypt last_o compare are not built.

## Test plan
- Zero key, tweak 0x0123456789ABCDEF, LANES=1, encrypt, tk_ready_i=1:
  - r0 = r1 = 0x0123456789ABCDEF; r2 = r3 = 0xCAF5E892B374601D; the sequence repeats with period 4.
  - last_o is high only at round 31; load_ready_o=1 on the next cycle.
- Key hi=0x0123456789ABCDEF, lo=0xFEDCBA9876543210, tweak 0:
  - TK alternates hi, lo, hi, lo.
  - round_o steps 0,1,2… with tk_valid_o first high one cycle after load.
- LANES=4, the key and tweak from the first scenario:
  - 8 beats; beat 0 = {lane3 0xCAF5E892B374601D, lane2 0xCAF5E892B374601D, lane1 0x0123456789ABCDEF, lane0 0x0123456789ABCDEF}.
  - round_o = 0,4,…,28.
- Random tk_ready_i backpressure (≈50%): outputs hold while stalled; no round is skipped or repeated; load_valid_i pulses during RUN are ignored.
- Decrypt (macro defined), LANES=1: round_o runs 31→0, TK[31] = K1^Q(T), and last_o is high at round 0. With the macro undefined, the same stimulus yields ascending order.
- rst asserted at round 10: the next cycle shows reset values. A new load then restarts cleanly from round 0.
